// File: rtl/mac_pkg.sv
// Shared definitions for the MAC job sequencer: mode encodings, data width
// and the controller FSM state type.
package mac_pkg;

    localparam logic MODE_FP16 = 1'b1;
    localparam logic MODE_INT8 = 1'b0;
    localparam int   DATA_W    = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CFG    = 3'd1,
        STREAM = 3'd2,
        READ   = 3'd3,
        RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/mac_job_ctrl.sv
// Job sequencer for the non-pipelined fp16/int8 MAC: takes a (mode, length)
// command, streams operand pairs into the MAC, reads back and returns the result.
module mac_job_ctrl #(
    parameter int LEN_W  = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_mode,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err,
    output logic              busy,
    output logic              mac_enable,
    output logic              mac_cfg,
    output logic              mac_mode,
    output logic              mac_valid,
    output logic              mac_read,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic [DATA_W-1:0] mac_out,
    input  logic              mac_error
);

    import mac_pkg::*;

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [LEN_W-1:0]   cnt_inc;
    logic               mode_q;
    logic               beat;
    logic               last_beat;

    assign beat      = (state == STREAM) && op_valid;
    assign cnt_inc   = cnt_q + 1'b1;
    // cnt_q + 1 never wraps: cnt_q tops out at len_q-1 <= 2**LEN_W-2.
    assign last_beat = beat && (cnt_inc == len_q);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            res_data <= '0;
            res_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && cmd_valid) begin
                len_q  <= cmd_len;
                mode_q <= cmd_mode;
                cnt_q  <= '0;
            end
            if (beat) begin
                cnt_q <= last_beat ? '0 : cnt_inc;
            end
            if (state == READ) begin
                res_data <= mac_out;
                res_err  <= mac_error;
            end
        end
    end

    // NOTE: every output and next-state is given a default first so no path
    // through the case statement leaves a value unassigned (no latches).
    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        op_ready   = 1'b0;
        res_valid  = 1'b0;
        mac_enable = 1'b0;
        mac_cfg    = 1'b0;
        mac_mode   = 1'b0;
        mac_valid  = 1'b0;
        mac_read   = 1'b0;
        mac_a      = '0;
        mac_b      = '0;
        case (state)
            IDLE: begin
                // Held low while reset is asserted so all outputs read 0 in reset.
                cmd_ready = rst_n;
                if (cmd_valid) state_nxt = CFG;
            end
            CFG: begin
                mac_cfg   = 1'b1;
                mac_mode  = mode_q;
                state_nxt = (len_q != '0) ? STREAM : READ;
            end
            STREAM: begin
                mac_enable = 1'b1;
                op_ready   = 1'b1;
                mac_valid  = op_valid;
                mac_a      = op_a;
                mac_b      = op_b;
                if (last_beat) state_nxt = READ;
            end
            READ: begin
                mac_enable = 1'b1;
                mac_read   = 1'b1;
                state_nxt  = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
